// File: rtl/micro_tile_switch_ctrl.sv
// Hand-over sequencer for micro tiles sharing one pin set: drains the outgoing tile
// under reset, cuts its clock, then clocks the incoming tile under reset before release.

module micro_tile_switch_lane #(
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             boot_i,
  input  logic             run_i,
  output logic             clk_en_o,
  output logic             rst_n_o
);
  localparam logic [SEL_W-1:0] ID = SEL_W'(IDX);
  logic hit;
  assign hit      = (sel_i == ID);
  assign clk_en_o = hit & ~boot_i;
  assign rst_n_o  = hit & run_i;
endmodule

module micro_tile_switch_ctrl #(
  parameter int NUM_TILES  = 4,
  parameter int SEL_W      = 2,
  parameter int RST_CYCLES = 4,
  parameter int DWELL_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  input  logic [SEL_W-1:0]     req_sel_i,
  output logic                 req_ready_o,
  output logic                 req_err_o,
  input  logic                 auto_en_i,
  input  logic [DWELL_W-1:0]   dwell_i,
  output logic [SEL_W-1:0]     active_sel_o,
  output logic [NUM_TILES-1:0] tile_clk_en_o,
  output logic [NUM_TILES-1:0] tile_rst_n_o,
  output logic                 out_valid_o,
  output logic                 busy_o
);
  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [SEL_W:0]   NT       = (SEL_W+1)'(NUM_TILES);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_TILES - 1);

  typedef enum logic [1:0] {RUN, DRAIN, HOLD} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   act_q, act_d, tgt_q, tgt_d, nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic               boot_q, boot_d, err_d;
  logic [NUM_TILES-1:0] ce_d, rn_d;

  assign nxt = (act_q == SEL_LAST) ? '0 : act_q + SEL_W'(1);

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    boot_d  = boot_q;
    err_d   = 1'b0;
    if (boot_q) begin
      // first edge after reset only turns the tile-0 clock on; HOLD count starts next
      boot_d = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == CNT_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            dcnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (cnt_q == CNT_LAST) begin
            state_d = HOLD;
            act_d   = tgt_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (req_valid_i) begin
            if ({1'b0, req_sel_i} >= NT) begin
              err_d  = 1'b1;
              dcnt_d = '0;
            end else if (req_sel_i == act_q) begin
              dcnt_d = '0;
            end else begin
              tgt_d   = req_sel_i;
              state_d = DRAIN;
              cnt_d   = '0;
            end
          end else if (auto_en_i && dwell_i != '0) begin
            // dwell is compared live so lowering it cuts the current slot short
            if (dcnt_q >= dwell_i - DWELL_W'(1)) begin
              tgt_d   = nxt;
              state_d = DRAIN;
              cnt_d   = '0;
            end else begin
              dcnt_d = dcnt_q + DWELL_W'(1);
            end
          end else if (!auto_en_i) begin
            dcnt_d = '0;
          end
        end
        default: state_d = HOLD;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_TILES; i++) begin : g_lane
    micro_tile_switch_lane #(.SEL_W(SEL_W), .IDX(i)) u_lane (
      .sel_i    (act_d),
      .boot_i   (boot_d),
      .run_i    (state_d == RUN),
      .clk_en_o (ce_d[i]),
      .rst_n_o  (rn_d[i])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= HOLD;
      act_q         <= '0;
      tgt_q         <= '0;
      cnt_q         <= '0;
      dcnt_q        <= '0;
      boot_q        <= 1'b1;
      tile_clk_en_o <= '0;
      tile_rst_n_o  <= '0;
      req_ready_o   <= 1'b0;
      req_err_o     <= 1'b0;
      out_valid_o   <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      act_q         <= act_d;
      tgt_q         <= tgt_d;
      cnt_q         <= cnt_d;
      dcnt_q        <= dcnt_d;
      boot_q        <= boot_d;
      tile_clk_en_o <= ce_d;
      tile_rst_n_o  <= rn_d;
      req_ready_o   <= (state_d == RUN);
      out_valid_o   <= (state_d == RUN);
      busy_o        <= ~boot_d & (state_d != RUN);
      req_err_o     <= err_d;
    end
  end

  assign active_sel_o = act_q;
endmodule
